ex_stage: RTL and testbench

//  Execute stage of the RV32I pipeline: accepts decoded instructions from decode, selects ALU operands,

---
 rtl/ex_stage_pkg.sv | 41 ++++
 rtl/ex_stage_alu.sv | 30 +++
 rtl/ex_stage_branch_unit.sv | 23 ++
 rtl/ex_stage.sv | 108 ++++++++++
 tb/tb_ex_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the RV32I execute stage: op classes, ALU function codes and
// the funct3/funct7 to ALU function mapping.
package ex_stage_pkg;

    localparam logic [2:0] OpReg    = 3'd0;
    localparam logic [2:0] OpImm    = 3'd1;
    localparam logic [2:0] OpLui    = 3'd2;
    localparam logic [2:0] OpAuipc  = 3'd3;
    localparam logic [2:0] OpJal    = 3'd4;
    localparam logic [2:0] OpJalr   = 3'd5;
    localparam logic [2:0] OpBranch = 3'd6;
    localparam logic [2:0] OpNop    = 3'd7;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSll  = 4'd1;
    localparam logic [3:0] AluSlt  = 4'd2;
    localparam logic [3:0] AluSltu = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSrl  = 4'd5;
    localparam logic [3:0] AluOr   = 4'd6;
    localparam logic [3:0] AluAnd  = 4'd7;
    localparam logic [3:0] AluSub  = 4'd8;

    // Only register-register ops honour funct7b5 for subtract; branches always compare via sub.
    function automatic logic [3:0] alu_fn_map(input logic [2:0] op, input logic [2:0] funct3,
                                              input logic funct7b5);
        logic [3:0] fn;
        fn = AluAdd;
        if (op == OpBranch) begin
            fn = AluSub;
        end else if (op == OpReg || op == OpImm) begin
            if (funct3 == 3'd0 && op == OpReg && funct7b5) begin
                fn = AluSub;
            end else begin
                fn = {1'b0, funct3};
            end
        end
        return fn;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU: add/sub, shifts, compares and bitwise ops with a zero flag.
module ex_stage_alu
    import ex_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  fn,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (fn)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluSll:  result = a << b[4:0];
            AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
            AluSltu: result = {31'b0, a < b};
            AluXor:  result = a ^ b;
            AluSrl:  result = a >> b[4:0];
            AluOr:   result = a | b;
            AluAnd:  result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage_branch_unit.sv
// Branch condition resolution; equality comes from the ALU zero flag on rs1 - rs2.
module ex_stage_branch_unit (
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        alu_zero,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'd0:    taken = alu_zero;
            3'd1:    taken = !alu_zero;
            3'd4:    taken = $signed(rs1) < $signed(rs2);
            3'd5:    taken = $signed(rs1) >= $signed(rs2);
            3'd6:    taken = rs1 < rs2;
            3'd7:    taken = rs1 >= rs2;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand select, ALU, branch/jump resolution and a one-deep
// valid/ready output register feeding writeback.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic [31:0] op_x, op_y, alu_res, sra_res, exe_result, target;
    logic [3:0]  alu_fn;
    logic        alu_zero, br_taken, redirect, exe_we, accept;

    assign op_x   = (in_op == OpAuipc) ? in_pc : in_rs1;
    assign op_y   = (in_op == OpReg || in_op == OpBranch) ? in_rs2 : in_imm;
    assign alu_fn = alu_fn_map(in_op, in_funct3, in_funct7b5);

    ex_stage_alu u_alu (
        .a      (op_x),
        .b      (op_y),
        .fn     (alu_fn),
        .result (alu_res),
        .zero   (alu_zero)
    );

    ex_stage_branch_unit u_branch_unit (
        .funct3   (in_funct3),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .alu_zero (alu_zero),
        .taken    (br_taken)
    );

    assign sra_res = $signed(op_x) >>> op_y[4:0];

    // SRA and SLTU are resolved here rather than trusting the ALU encoding for them.
    always_comb begin
        exe_result = alu_res;
        case (in_op)
            OpLui:         exe_result = in_imm;
            OpJal, OpJalr: exe_result = in_pc + 32'd4;
            OpReg, OpImm: begin
                if (in_funct3 == 3'd5 && in_funct7b5) begin
                    exe_result = sra_res;
                end else if (in_funct3 == 3'd3) begin
                    exe_result = {31'b0, op_x < op_y};
                end
            end
            default:       exe_result = alu_res;
        endcase
    end

    assign target   = (in_op == OpJalr) ? ((in_rs1 + in_imm) & ~32'd1) : (in_pc + in_imm);
    assign redirect = (in_op == OpJal) || (in_op == OpJalr) || (in_op == OpBranch && br_taken);
    assign exe_we   = (in_op != OpBranch) && (in_op != OpNop) && (in_rd != 5'd0);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // redirect_valid only rises on the accept edge, so a stalled jump never re-pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_we         <= 1'b0;
            out_result     <= '0;
            out_rd         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            redirect_valid <= 1'b0;
            if (flush) begin
                out_valid <= 1'b0;
                out_we    <= 1'b0;
            end else if (accept) begin
                out_valid      <= 1'b1;
                out_we         <= exe_we;
                out_result     <= exe_result;
                out_rd         <= in_rd;
                redirect_valid <= redirect;
                if (redirect) begin
                    redirect_pc <= target;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver pushes expected results from an instruction-level
// model, a negedge monitor pops and compares whenever a new result is presented.
module tb_ex_stage;

    localparam logic [2:0] OP = 3'd0, OP_IMM = 3'd1, LUI = 3'd2, AUIPC = 3'd3;
    localparam logic [2:0] JAL = 3'd4, JALR = 3'd5, BRANCH = 3'd6, NOP = 3'd7;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        redir;
        logic [31:0] rpc;
        logic        has_result;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_funct7b5, out_valid, out_ready;
    logic        out_we, redirect_valid;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm, out_result, redirect_pc;
    logic [2:0]  in_op, in_funct3;
    logic [4:0]  in_rd, out_rd;

    ex_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_op          (in_op),
        .in_funct3      (in_funct3),
        .in_funct7b5    (in_funct7b5),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .in_rd          (in_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_we         (out_we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic mvalid = 1'b0;
    logic p_rs = 1'b1, p_fl = 1'b0, p_acc = 1'b0, p_ordy = 1'b1;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction semantics straight from the RV32I definitions.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [2:0] f3,
                                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] imm, input logic [31:0] pc,
                                       input logic [4:0] rd);
        exp_t        e;
        logic [31:0] src;
        int unsigned sh;
        e = '0;
        e.rd = rd;
        src = (op == OP) ? b : imm;
        sh = src[4:0];
        case (op)
            OP, OP_IMM: begin
                case (f3)
                    3'd0: e.result = (op == OP && f7) ? a - src : a + src;
                    3'd1: e.result = a << sh;
                    3'd2: e.result = ($signed(a) < $signed(src)) ? 32'd1 : 32'd0;
                    3'd3: e.result = (a < src) ? 32'd1 : 32'd0;
                    3'd4: e.result = a ^ src;
                    3'd5: begin
                        if (f7) e.result = $signed(a) >>> sh;
                        else    e.result = a >> sh;
                    end
                    3'd6: e.result = a | src;
                    default: e.result = a & src;
                endcase
            end
            LUI:   e.result = imm;
            AUIPC: e.result = pc + imm;
            JAL: begin
                e.result = pc + 4;
                e.redir  = 1'b1;
                e.rpc    = pc + imm;
            end
            JALR: begin
                e.result = pc + 4;
                e.redir  = 1'b1;
                e.rpc    = (a + imm) & 32'hFFFF_FFFE;
            end
            BRANCH: begin
                case (f3)
                    3'd0: e.redir = (a == b);
                    3'd1: e.redir = (a != b);
                    3'd4: e.redir = ($signed(a) < $signed(b));
                    3'd5: e.redir = ($signed(a) >= $signed(b));
                    3'd6: e.redir = (a < b);
                    3'd7: e.redir = (a >= b);
                    default: e.redir = 1'b0;
                endcase
                e.rpc = pc + imm;
            end
            default: e.redir = 1'b0;
        endcase
        e.has_result = (op != BRANCH) && (op != NOP);
        e.we = e.has_result && (rd != 5'd0);
        return e;
    endfunction

    // One clock of stimulus; the occupancy model advances using last cycle's decisions.
    task automatic step(input logic v, input logic fl, input logic rs, input logic ordy,
                        input logic [2:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd);
        logic acc;
        @(posedge clk);
        if (p_rs || p_fl)          mvalid = 1'b0;
        else if (p_acc)            mvalid = 1'b1;
        else if (mvalid && p_ordy) mvalid = 1'b0;
        #2;
        in_valid = v; flush = fl; rst = rs; out_ready = ordy;
        in_op = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = imm; in_pc = pc; in_rd = rd;
        acc = v && !fl && !rs && (!mvalid || ordy);
        if (acc) q.push_back(ref_model(op, f3, f7, a, b, imm, pc, rd));
        p_rs = rs; p_fl = fl; p_acc = acc; p_ordy = ordy;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, ordy, NOP, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    logic        prev_v = 1'b0, prev_cons = 1'b0;
    exp_t        held;
    logic [31:0] held_result, held_rpc;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
            chk("in_ready", {31'b0, in_ready}, {31'b0, !mvalid || out_ready});
            if (out_valid) begin
                if (!prev_v || prev_cons) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got result %h expected none", out_result);
                    end else begin
                        held = q.pop_front();
                        if (held.has_result) chk("result", out_result, held.result);
                        chk("rd", {27'b0, out_rd}, {27'b0, held.rd});
                        chk("we", {31'b0, out_we}, {31'b0, held.we});
                        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, held.redir});
                        if (held.redir) chk("redirect_pc", redirect_pc, held.rpc);
                        held_result = out_result;
                        held_rpc = redirect_pc;
                    end
                end else begin
                    chk("stall_result", out_result, held_result);
                    chk("stall_rd", {27'b0, out_rd}, {27'b0, held.rd});
                    chk("stall_we", {31'b0, out_we}, {31'b0, held.we});
                    chk("stall_redirect_pc", redirect_pc, held_rpc);
                    chk("stall_no_repulse", {31'b0, redirect_valid}, 32'd0);
                end
            end else begin
                chk("idle_redirect", {31'b0, redirect_valid}, 32'd0);
            end
            prev_v = out_valid;
            prev_cons = out_valid && out_ready;
        end
    end

    task automatic chk_reset_values(input string tag);
        #1;
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_we"}, {31'b0, out_we}, 32'd0);
        chk({tag, "_out_result"}, out_result, 32'd0);
        chk({tag, "_out_rd"}, {27'b0, out_rd}, 32'd0);
        chk({tag, "_redirect_valid"}, {31'b0, redirect_valid}, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        logic [2:0]  rop, rf3;
        logic [31:0] ra, rb, rimm, r;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = NOP; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rd = '0;

        step(1'b0, 1'b0, 1'b1, 1'b1, NOP, 3'd0, 1'b0, 0, 0, 0, 0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, NOP, 3'd0, 1'b0, 0, 0, 0, 0, 5'd0);
        idle(1'b1);
        chk_reset_values("reset");
        mon_en = 1'b1;

        // Directed instructions, full throughput.
        step(1'b1, 1'b0, 1'b0, 1'b1, OP, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h0, 5'd3);
        step(1'b1, 1'b0, 1'b0, 1'b1, OP, 3'd0, 1'b1, 32'd0, 32'd1, 32'd0, 32'h4, 5'd4);
        #1 chk("add_result", out_result, 32'd12);
        chk("add_we", {31'b0, out_we}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, OP_IMM, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h8, 5'd7);
        #1 chk("sub_result", out_result, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 1'b0, 1'b1, BRANCH, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0,
             32'h100, 5'd9);
        #1 chk("sra_result", out_result, 32'hF800_0000);
        step(1'b1, 1'b0, 1'b0, 1'b1, BRANCH, 3'd4, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0,
             32'h104, 5'd9);
        #1 chk("bltu_redirect", {31'b0, redirect_valid}, 32'd1);
        chk("bltu_target", redirect_pc, 32'h0000_00F0);
        chk("bltu_we", {31'b0, out_we}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, JALR, 3'd0, 1'b0, 32'h203, 32'd0, 32'd0, 32'h40, 5'd1);
        #1 chk("blt_not_taken", {31'b0, redirect_valid}, 32'd0);
        idle(1'b1);
        #1 chk("jalr_result", out_result, 32'h44);
        chk("jalr_target", redirect_pc, 32'h202);

        // Stall three cycles on a held jump with the next instruction waiting.
        step(1'b1, 1'b0, 1'b0, 1'b1, JAL, 3'd0, 1'b0, 32'd0, 32'd0, 32'h20, 32'h200, 5'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, OP_IMM, 3'd0, 1'b0, 32'd1, 32'd0, 32'd2, 32'h220, 5'd2);
        end
        #1 chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, OP_IMM, 3'd0, 1'b0, 32'd1, 32'd0, 32'd2, 32'h220, 5'd2);
        idle(1'b1);
        idle(1'b1);

        // Flush with a held result and a new instruction offered.
        step(1'b1, 1'b0, 1'b0, 1'b1, JAL, 3'd0, 1'b0, 32'd0, 32'd0, 32'h10, 32'h300, 5'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0, OP, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'h304, 5'd6);
        step(1'b1, 1'b1, 1'b0, 1'b0, OP, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'h304, 5'd6);
        idle(1'b1);
        #1 chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_out_we", {31'b0, out_we}, 32'd0);
        chk("flush_redirect", {31'b0, redirect_valid}, 32'd0);

        // Reset while stalled.
        step(1'b1, 1'b0, 1'b0, 1'b1, OP, 3'd0, 1'b0, 32'd9, 32'd1, 32'd0, 32'h400, 5'd8);
        step(1'b1, 1'b0, 1'b0, 1'b0, LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h404, 5'd9);
        step(1'b1, 1'b0, 1'b1, 1'b0, LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h404, 5'd9);
        idle(1'b1);
        chk_reset_values("rst_stall");

        // Randomised traffic with backpressure, flushes and occasional resets.
        for (int i = 0; i < 800; i++) begin
            r    = $urandom;
            rop  = r[2:0];
            rf3  = r[5:3];
            ra   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
            rb   = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            rimm = $urandom;
            rimm = (rop == LUI) ? {rimm[19:0], 12'b0} : {{20{rimm[11]}}, rimm[11:0]};
            step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7, rop, rf3, r[6], ra, rb, rimm, $urandom, r[11:7]);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
